lsu_dmem_master: RTL and testbench
==================================

Name: lsu_dmem_master

Overview:
- Load/store unit on the CPU side of the data-memory port; it is the initiator for the word-wide, single-write-enable data RAM.
- Accepts one RV32I load/store request at a time from the MEM stage.
- Drives the RAM's word address, write enable and write data, and returns sign/zero-extended load data.
- Implements SB/SH by read-modify-write, because the RAM has only a full-word write enable.
- Flags misaligned, out-of-range and illegal-funct3 accesses without touching memory.

Parameters:
- DEPTH, 4096, RAM size in 32-bit words; any word index >= DEPTH is an access fault.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3 (LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the low byte or halfword is used for SB/SH.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_data  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  qualifies rsp_valid; the access was rejected.
- mem_addr  output  32  byte address to RAM, low two bits always 00.
- mem_wen  output  1  RAM word write enable.
- mem_wdata  output  32  RAM write data.
- mem_rdata  input  32  RAM read data, valid one cycle after mem_addr is presented (registered read).

Behaviour:

Reset (rst_n low at posedge):
- state = IDLE; mem_wen = 0; mem_addr = 0; mem_wdata = 0; rsp_valid = 0; rsp_data = 0; rsp_err = 0.
- A write already in progress during the reset cycle (mem_wen = 1) still lands, because mem_wen is a registered output. No further RAM access follows.

Registers:
- All outputs except req_ready are registered.
- req_ready = (state == IDLE), combinational.

Accept (IDLE with req_valid):
- Latch store, funct3, addr, wdata.
- Error check, each condition sets error:
  - illegal funct3: loads 011/110/111; stores any value other than 000/001/010.
  - halfword with addr[0] = 1.
  - word with addr[1:0] != 0.
  - addr[31:2] >= DEPTH.
- On error: go to RESP, rsp_err = 1. No RAM access; mem_wen stays 0.
- Otherwise:
  - mem_addr <= {addr[31:2], 2'b00}.
  - Load → RD_ISSUE.
  - SW → WR_ISSUE, with mem_wen <= 1 and mem_wdata <= wdata.
  - SB/SH → RD_ISSUE, flagged RMW.

States:
- RD_ISSUE: mem_addr stable; RAM samples it. → RD_WAIT.
- RD_WAIT, mem_rdata valid:
  - Load: select byte lane addr[1:0] or halfword lane addr[1]. Sign-extend (LB/LH) or zero-extend (LBU/LHU); LW passes the word through. Register into rsp_data with rsp_valid = 1. → IDLE.
  - RMW: merge the new byte/halfword into mem_rdata at the lane; mem_wdata <= merged; mem_wen <= 1. → WR_ISSUE.
- WR_ISSUE: mem_wen = 1 for exactly this cycle. Next edge: mem_wen <= 0, rsp_valid <= 1, rsp_data <= 0. → IDLE.
- RESP (error path): rsp_valid = 1 and rsp_err = 1 appear with the transition into RESP. → IDLE next cycle.
- rsp_valid is one cycle wide. rsp_err = 0 on every non-error response.

Latency (accept edge = cycle 0):
- Error: rsp_valid at cycle 1.
- SW: mem_wen at cycle 1, rsp_valid at cycle 2.
- Load: rsp_valid at cycle 3.
- SB/SH: mem_wen at cycle 3, rsp_valid at cycle 4.

Back-to-back:
- A new request may be accepted in the same cycle that rsp_valid is high (state is IDLE).
- A load immediately following a store to the same word returns the new data, because the write edge precedes the read issue.

Other rules:
- mem_addr holds its last value while IDLE. Reads in IDLE are don't-care; mem_wen is never 1 outside WR_ISSUE.
- req_* inputs are ignored when not in IDLE.

Test Plan:
- RAM word 0x10 = 0x80FF7F01 (byte address 0x40). LB at 0x41 → rsp_data 0x0000007F. LB at 0x43 → 0xFFFFFF80. LBU at 0x43 → 0x00000080. Each response arrives at cycle 3.
- LH 0x42 → 0xFFFF80FF. LHU 0x42 → 0x000080FF. LW 0x40 → 0x80FF7F01.
- SB 0xAB at 0x42 over 0x80FF7F01 → single mem_wen pulse at cycle 3 with mem_wdata 0x80AB7F01. LW 0x40 afterwards → 0x80AB7F01. SH 0x1234 at 0x40 → word becomes 0x80AB1234.
- Errors: LW 0x41, SH 0x43, LB with funct3 011, SW at address 4*DEPTH → rsp_err = 1 at cycle 1, rsp_data 0, mem_wen never asserted.
- SW 0xDEADBEEF at 0x80, then a load accepted in the cycle rsp_valid is high: LW 0x80 → 0xDEADBEEF, no idle gap between the two transactions.
- rst_n low during RD_WAIT of an SB → no mem_wen afterwards, no rsp_valid, RAM word unchanged, req_ready = 1 the cycle after reset releases.

Source files
------------

// File: rtl/lsu_dmem_master_if.sv
//------------------------------------------------------------------------------
// Module : lsu_dmem_master_if
// Brief  : MEM-stage request/response and data-RAM port bundle for the LSU.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface lsu_dmem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_wen, mem_wdata
  );

  modport slave (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_wen, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/lsu_dmem_master.sv
//------------------------------------------------------------------------------
// Module : lsu_dmem_master
// Brief  : RV32I load/store unit driving a word-wide, single-write-enable RAM.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsu_dmem_master #(
  parameter int DEPTH = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  lsu_dmem_master_if.master         io_dmem
);

  localparam logic [31:0] c_depth = 32'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR_ISSUE = 3'd3,
    ST_RESP     = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_store;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic [15:0] r_wdata_lo;

  logic [31:0] r_mem_addr;
  logic        r_mem_wen;
  logic [31:0] r_mem_wdata;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic        r_rsp_err;

  logic [31:0] w_mem_addr_nxt;
  logic        w_mem_wen_nxt;
  logic [31:0] w_mem_wdata_nxt;
  logic        w_rsp_valid_nxt;
  logic [31:0] w_rsp_data_nxt;
  logic        w_rsp_err_nxt;

  logic        w_accept;
  logic        w_f3_ok;
  logic        w_misalign;
  logic        w_range_err;
  logic        w_req_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [3:0]  w_lane_mask;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_merged;

  assign w_accept = (r_state == ST_IDLE) && io_dmem.req_valid;

  // Request qualification, evaluated on the incoming (unlatched) request
  always_comb begin
    w_f3_ok = 1'b0;
    if (io_dmem.req_store) begin
      w_f3_ok = io_dmem.req_funct3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      w_f3_ok = io_dmem.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
  end

  assign w_misalign  = ((io_dmem.req_funct3[1:0] == 2'b01) && io_dmem.req_addr[0]) ||
                       ((io_dmem.req_funct3[1:0] == 2'b10) && (io_dmem.req_addr[1:0] != 2'b00));
  assign w_range_err = {2'b00, io_dmem.req_addr[31:2]} >= c_depth;
  assign w_req_err   = !w_f3_ok || w_misalign || w_range_err;

  // Load lane extraction and extension
  always_comb begin
    w_byte = io_dmem.mem_rdata[7:0];
    case (r_addr_lo)
      2'd0:    w_byte = io_dmem.mem_rdata[7:0];
      2'd1:    w_byte = io_dmem.mem_rdata[15:8];
      2'd2:    w_byte = io_dmem.mem_rdata[23:16];
      default: w_byte = io_dmem.mem_rdata[31:24];
    endcase
    w_half = r_addr_lo[1] ? io_dmem.mem_rdata[31:16] : io_dmem.mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = io_dmem.mem_rdata;
    endcase
  end

  // Sub-word store merge: replicate the new data across lanes, then pick per byte
  assign w_lane_mask = (r_funct3[1:0] == 2'b00) ? (4'b0001 << r_addr_lo)
                                                 : (r_addr_lo[1] ? 4'b1100 : 4'b0011);
  assign w_wdata_rep = r_funct3[0] ? {2{r_wdata_lo}} : {4{r_wdata_lo[7:0]}};

  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign w_merged[8*gi +: 8] = w_lane_mask[gi] ? w_wdata_rep[8*gi +: 8]
                                                 : io_dmem.mem_rdata[8*gi +: 8];
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wen_nxt   = 1'b0;
    w_mem_wdata_nxt = r_mem_wdata;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_data_nxt  = 32'd0;
    w_rsp_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_dmem.req_valid) begin
          if (w_req_err) begin
            w_state_nxt     = ST_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
          end else begin
            w_mem_addr_nxt = {io_dmem.req_addr[31:2], 2'b00};
            if (io_dmem.req_store && (io_dmem.req_funct3 == 3'b010)) begin
              w_state_nxt     = ST_WR_ISSUE;
              w_mem_wen_nxt   = 1'b1;
              w_mem_wdata_nxt = io_dmem.req_wdata;
            end else begin
              w_state_nxt = ST_RD_ISSUE;
            end
          end
        end
      end
      ST_RD_ISSUE: w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (r_store) begin
          w_state_nxt     = ST_WR_ISSUE;
          w_mem_wen_nxt   = 1'b1;
          w_mem_wdata_nxt = w_merged;
        end else begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = w_load_data;
        end
      end
      ST_WR_ISSUE: begin
        w_state_nxt     = ST_IDLE;
        w_rsp_valid_nxt = 1'b1;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_store     <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr_lo   <= 2'd0;
      r_wdata_lo  <= 16'd0;
      r_mem_addr  <= 32'd0;
      r_mem_wen   <= 1'b0;
      r_mem_wdata <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wen   <= w_mem_wen_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      if (w_accept) begin
        r_store    <= io_dmem.req_store;
        r_funct3   <= io_dmem.req_funct3;
        r_addr_lo  <= io_dmem.req_addr[1:0];
        r_wdata_lo <= io_dmem.req_wdata[15:0];
      end
    end
  end

  assign io_dmem.req_ready = (r_state == ST_IDLE);
  assign io_dmem.mem_addr  = r_mem_addr;
  assign io_dmem.mem_wen   = r_mem_wen;
  assign io_dmem.mem_wdata = r_mem_wdata;
  assign io_dmem.rsp_valid = r_rsp_valid;
  assign io_dmem.rsp_data  = r_rsp_data;
  assign io_dmem.rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_lsu_dmem_master.sv
//------------------------------------------------------------------------------
// Module : tb_lsu_dmem_master
// Brief  : Directed self-checking bench for lsu_dmem_master with a registered-read RAM.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lsu_dmem_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_dmem_master_if bus ();

  lsu_dmem_master #(.DEPTH(4096)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .io_dmem (bus.master)
  );

  logic [31:0] ram [0:4095];
  int          wen_count = 0;
  logic [31:0] last_wdata = 32'd0;

  always @(posedge clk) begin
    if (bus.mem_wen) begin
      ram[bus.mem_addr[13:2]] <= bus.mem_wdata;
      wen_count               <= wen_count + 1;
      last_wdata              <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr[13:2]];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction: drive at negedge, accept at next posedge (cycle 0),
  // then sample #1 after each edge; edge k output is reported as cycle k+1.
  task automatic txn(input string tag, input logic st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int exp_lat, input logic [31:0] exp_d, input logic exp_e,
                     input int exp_wens, input int exp_wen_lat);
    int lat;
    int wen_lat;
    int w0;
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s/ready", tag), 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    w0      = wen_count;
    lat     = 0;
    wen_lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) bus.req_valid = 1'b0;
      if (bus.mem_wen && wen_lat == 0) wen_lat = lat;
    end while (!bus.rsp_valid && lat < 10);
    check($sformatf("%s/lat", tag), 32'(lat), 32'(exp_lat));
    check($sformatf("%s/data", tag), bus.rsp_data, exp_d);
    check($sformatf("%s/err", tag), 32'(bus.rsp_err), 32'(exp_e));
    check($sformatf("%s/wens", tag), 32'(wen_count - w0), 32'(exp_wens));
    check($sformatf("%s/wenlat", tag), 32'(wen_lat), 32'(exp_wen_lat));
  endtask

  initial begin
    int w0;
    int seen;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    check("rst/ready", 32'(bus.req_ready), 32'd1);
    check("rst/wen",   32'(bus.mem_wen),   32'd0);
    check("rst/addr",  bus.mem_addr,       32'd0);
    check("rst/wdata", bus.mem_wdata,      32'd0);
    check("rst/rvld",  32'(bus.rsp_valid), 32'd0);
    check("rst/rdata", bus.rsp_data,       32'd0);
    check("rst/rerr",  32'(bus.rsp_err),   32'd0);
    rst_n = 1'b1;

    txn("sw40",  1'b1, 3'b010, 32'h40, 32'h80FF7F01, 2, 32'h0, 1'b0, 1, 1);
    check("sw40/wdata", last_wdata, 32'h80FF7F01);
    txn("lb41",  1'b0, 3'b000, 32'h41, 32'h0, 3, 32'h0000007F, 1'b0, 0, 0);
    txn("lb43",  1'b0, 3'b000, 32'h43, 32'h0, 3, 32'hFFFFFF80, 1'b0, 0, 0);
    txn("lbu43", 1'b0, 3'b100, 32'h43, 32'h0, 3, 32'h00000080, 1'b0, 0, 0);
    txn("lh42",  1'b0, 3'b001, 32'h42, 32'h0, 3, 32'hFFFF80FF, 1'b0, 0, 0);
    txn("lhu42", 1'b0, 3'b101, 32'h42, 32'h0, 3, 32'h000080FF, 1'b0, 0, 0);
    txn("lw40",  1'b0, 3'b010, 32'h40, 32'h0, 3, 32'h80FF7F01, 1'b0, 0, 0);

    txn("sb42",  1'b1, 3'b000, 32'h42, 32'h123456AB, 4, 32'h0, 1'b0, 1, 3);
    check("sb42/wdata", last_wdata, 32'h80AB7F01);
    txn("lw40b", 1'b0, 3'b010, 32'h40, 32'h0, 3, 32'h80AB7F01, 1'b0, 0, 0);
    txn("sh40",  1'b1, 3'b001, 32'h40, 32'hFFFF1234, 4, 32'h0, 1'b0, 1, 3);
    check("sh40/wdata", last_wdata, 32'h80AB1234);
    txn("lw40c", 1'b0, 3'b010, 32'h40, 32'h0, 3, 32'h80AB1234, 1'b0, 0, 0);

    txn("e_lw41",  1'b0, 3'b010, 32'h41,   32'h0, 1, 32'h0, 1'b1, 0, 0);
    txn("e_sh43",  1'b1, 3'b001, 32'h43,   32'h5555, 1, 32'h0, 1'b1, 0, 0);
    txn("e_f3011", 1'b0, 3'b011, 32'h40,   32'h0, 1, 32'h0, 1'b1, 0, 0);
    txn("e_swoor", 1'b1, 3'b010, 32'h4000, 32'h11111111, 1, 32'h0, 1'b1, 0, 0);
    txn("e_sf3",   1'b1, 3'b100, 32'h40,   32'h22, 1, 32'h0, 1'b1, 0, 0);
    txn("lw40d",   1'b0, 3'b010, 32'h40,   32'h0, 3, 32'h80AB1234, 1'b0, 0, 0);

    txn("sw80", 1'b1, 3'b010, 32'h80, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1, 1);
    check("b2b/rvld",  32'(bus.rsp_valid), 32'd1);
    check("b2b/ready", 32'(bus.req_ready), 32'd1);
    txn("lw80", 1'b0, 3'b010, 32'h80, 32'h0, 3, 32'hDEADBEEF, 1'b0, 0, 0);

    // Reset lands while the SB read-modify-write sits in RD_WAIT
    @(negedge clk);
    w0 = wen_count;
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h40;
    bus.req_wdata  = 32'h55;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    check("rstmid/wen", 32'(bus.mem_wen), 32'd0);
    check("rstmid/ready", 32'(bus.req_ready), 32'd1);
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid || bus.mem_wen) seen++;
    end
    check("rstmid/quiet", 32'(seen), 32'd0);
    check("rstmid/wens", 32'(wen_count - w0), 32'd0);
    txn("lw40e", 1'b0, 3'b010, 32'h40, 32'h0, 3, 32'h80AB1234, 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
